// File: rtl/deser8way_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deser8way_pkg
// Description : Shared constants and types for the 8-way serial deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
package deser8way_pkg;

   localparam int       FRAME_BITS        = 8;
   localparam int       CNT_W             = 3;
   localparam bit       LSB_FIRST_DEFAULT = 1'b1;

   // COLLECT: bits are being gathered. STALLED: a completed frame waits for O.
   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_STALLED = 1'b1
   } deser_state_e;

   // Position within C for the n-th accepted bit of a frame.
   function automatic logic [CNT_W-1:0] place_idx(input logic [CNT_W-1:0] n,
                                                  input bit lsb_first);
      return lsb_first ? n : (CNT_W'(FRAME_BITS - 1) - n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/Or8Way.sv
`default_nettype none
// ============================================================================
// Module      : Or8Way
// Description : Combinational 8-input OR reduction.
// Revision    : 1.0 - initial release
// ============================================================================
module Or8Way (
   input  logic [7:0] in,
   output logic       out
);

   assign out = |in;

endmodule
`default_nettype wire

// File: rtl/deser8way_slot.sv
`default_nettype none
// ============================================================================
// Module      : deser8way_slot
// Description : Output frame register with valid/ready handshake and the
//               registered OR-of-frame flag.
// Revision    : 1.0 - initial release
// ============================================================================
module deser8way_slot
   import deser8way_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [FRAME_BITS-1:0] load_data,
   input  logic                  consume,
   output logic [FRAME_BITS-1:0] frame,
   output logic                  out_valid,
   output logic                  nonzero
);

   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic                  valid_q, valid_d;
   logic                  nonzero_q, nonzero_d;
   logic                  load_or;

   // OR of the frame being loaded, so nonzero is ready in the same cycle as O.
   Or8Way u_or8 (
      .in  (load_data),
      .out (load_or)
   );

   // Load replaces the frame; a consume without a new frame only drops valid,
   // leaving O and nonzero at their stale values.
   always_comb begin
      frame_d   = frame_q;
      nonzero_d = nonzero_q;
      valid_d   = valid_q;
      if (load) begin
         frame_d   = load_data;
         nonzero_d = load_or;
         valid_d   = 1'b1;
      end else if (consume) begin
         valid_d   = 1'b0;
      end
   end

   // Output register state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_q   <= '0;
         valid_q   <= 1'b0;
         nonzero_q <= 1'b0;
      end else begin
         frame_q   <= frame_d;
         valid_q   <= valid_d;
         nonzero_q <= nonzero_d;
      end
   end

   assign frame     = frame_q;
   assign out_valid = valid_q;
   assign nonzero   = nonzero_q;

endmodule
`default_nettype wire

// File: rtl/deser8way.sv
`default_nettype none
// ============================================================================
// Module      : deser8way
// Description : Serial-to-parallel 8-way fan-out. Collects eight accepted bits
//               into C, hands the frame to the output slot, and holds one
//               completed frame pending while the slot is busy.
// Revision    : 1.0 - initial release
// ============================================================================
module deser8way
   import deser8way_pkg::*;
#(
   parameter bit LSB_FIRST = LSB_FIRST_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             clear,
   output logic             out0,
   output logic             out1,
   output logic             out2,
   output logic             out3,
   output logic             out4,
   output logic             out5,
   output logic             out6,
   output logic             out7,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             nonzero,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0]      count_q, count_d;
   logic [FRAME_BITS-1:0] collect_q, collect_d;
   logic                  pending_q, pending_d;

   logic [FRAME_BITS-1:0] placed;
   logic [FRAME_BITS-1:0] load_data;
   logic [FRAME_BITS-1:0] frame;
   logic                  load;
   logic                  accept;
   logic                  consume;
   deser_state_e          state;

   assign state    = pending_q ? ST_STALLED : ST_COLLECT;
   assign in_ready = (state == ST_COLLECT);
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid && out_ready;

   // C with the incoming bit dropped into its slot for this count.
   always_comb begin
      placed = collect_q;
      placed[place_idx(count_q, LSB_FIRST)] = in;
   end

   // Collection, completion and pending-drain control. clear overrides all.
   always_comb begin
      count_d   = count_q;
      collect_d = collect_q;
      pending_d = pending_q;
      load      = 1'b0;
      load_data = collect_q;
      if (clear) begin
         count_d   = '0;
         collect_d = '0;
         pending_d = 1'b0;
      end else if (pending_q) begin
         if (consume) begin
            load      = 1'b1;
            load_data = collect_q;
            collect_d = '0;
            pending_d = 1'b0;
         end
      end else if (accept) begin
         count_d   = count_q + 1'b1;
         collect_d = placed;
         if (count_q == CNT_W'(FRAME_BITS - 1)) begin
            if (!out_valid || consume) begin
               load      = 1'b1;
               load_data = placed;
               collect_d = '0;
            end else begin
               pending_d = 1'b1;
            end
         end
      end
   end

   // Collector state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         collect_q <= '0;
         pending_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         collect_q <= collect_d;
         pending_q <= pending_d;
      end
   end

   deser8way_slot u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_data (load_data),
      .consume   (consume),
      .frame     (frame),
      .out_valid (out_valid),
      .nonzero   (nonzero)
   );

   assign {out7, out6, out5, out4, out3, out2, out1, out0} = frame;
   assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_deser8way.sv
`default_nettype none
// ============================================================================
// Module      : tb_deser8way
// Description : Directed self-checking bench for deser8way. Two instances
//               share stimulus: one LSB-first, one MSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deser8way;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in = 1'b0;
   logic       in_valid = 1'b0;
   logic       clear = 1'b0;
   logic       out_ready = 1'b0;

   logic       in_ready_l, out_valid_l, nonzero_l;
   logic [2:0] count_l;
   logic [7:0] outs_l;
   logic       in_ready_m, out_valid_m, nonzero_m;
   logic [2:0] count_m;
   logic [7:0] outs_m;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   deser8way #(.LSB_FIRST(1'b1)) dut_lsb (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
      .in_ready(in_ready_l), .clear(clear),
      .out0(outs_l[0]), .out1(outs_l[1]), .out2(outs_l[2]), .out3(outs_l[3]),
      .out4(outs_l[4]), .out5(outs_l[5]), .out6(outs_l[6]), .out7(outs_l[7]),
      .out_valid(out_valid_l), .out_ready(out_ready), .nonzero(nonzero_l),
      .count(count_l)
   );

   deser8way #(.LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
      .in_ready(in_ready_m), .clear(clear),
      .out0(outs_m[0]), .out1(outs_m[1]), .out2(outs_m[2]), .out3(outs_m[3]),
      .out4(outs_m[4]), .out5(outs_m[5]), .out6(outs_m[6]), .out7(outs_m[7]),
      .out_valid(out_valid_m), .out_ready(out_ready), .nonzero(nonzero_m),
      .count(count_m)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Send the low nbits of b, bit 0 first, one accept per cycle.
   task automatic send_bits(input logic [7:0] b, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         in = b[i];
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      int seen_valid;

      // Reset state
      #2;
      check("rst_count", {5'd0, count_l}, 8'd0);
      check("rst_valid", {7'd0, out_valid_l}, 8'd0);
      check("rst_ready", {7'd0, in_ready_l}, 8'd1);
      check("rst_nonzero", {7'd0, nonzero_l}, 8'd0);
      check("rst_outs", outs_l, 8'h00);
      @(negedge clk); reset = 1'b0;
      step();

      // Reset mid-frame after 3 bits
      out_ready = 1'b1;
      send_bits(8'b0000_0111, 3);
      check("mid_count3", {5'd0, count_l}, 8'd3);
      #2 reset = 1'b1;
      #1;
      check("async_count", {5'd0, count_l}, 8'd0);
      check("async_valid", {7'd0, out_valid_l}, 8'd0);
      check("async_ready", {7'd0, in_ready_l}, 8'd1);
      #1 reset = 1'b0;
      seen_valid = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_valid_l) seen_valid = 1;
      end
      check("no_frame_after_rst", 8'(seen_valid), 8'd0);

      // Basic frame 1,0,1,1,0,0,0,1 (first bit first)
      send_bits(8'b1000_1101, 8);
      check("basic_valid", {7'd0, out_valid_l}, 8'd1);
      check("basic_outs", outs_l, 8'h8D);
      check("basic_nonzero", {7'd0, nonzero_l}, 8'd1);
      check("basic_count", {5'd0, count_l}, 8'd0);
      // Ordering: MSB-first instance lands the first bit on out7
      check("msb_valid", {7'd0, out_valid_m}, 8'd1);
      check("msb_outs", outs_m, 8'hB1);
      step();
      check("basic_consumed", {7'd0, out_valid_l}, 8'd0);

      // Zero frame
      send_bits(8'h00, 8);
      check("zero_valid", {7'd0, out_valid_l}, 8'd1);
      check("zero_nonzero", {7'd0, nonzero_l}, 8'd0);
      check("zero_outs", outs_l, 8'h00);
      step();

      // Backpressure: two frames with out_ready low
      out_ready = 1'b0;
      send_bits(8'hA5, 8);
      check("bp_first_valid", {7'd0, out_valid_l}, 8'd1);
      check("bp_first_outs", outs_l, 8'hA5);
      check("bp_ready_mid", {7'd0, in_ready_l}, 8'd1);
      send_bits(8'h3C, 8);
      check("bp_held_outs", outs_l, 8'hA5);
      check("bp_stalled", {7'd0, in_ready_l}, 8'd0);
      check("bp_count", {5'd0, count_l}, 8'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("drain_valid", {7'd0, out_valid_l}, 8'd1);
      check("drain_outs", outs_l, 8'h3C);
      check("drain_nonzero", {7'd0, nonzero_l}, 8'd1);
      check("drain_ready", {7'd0, in_ready_l}, 8'd1);

      // Clear together with in_valid at count=5
      send_bits(8'h1F, 5);
      check("pre_clear_count", {5'd0, count_l}, 8'd5);
      in = 1'b1; in_valid = 1'b1; clear = 1'b1;
      step();
      in_valid = 1'b0; clear = 1'b0; in = 1'b0;
      check("clear_count", {5'd0, count_l}, 8'd0);
      check("clear_keeps_valid", {7'd0, out_valid_l}, 8'd1);
      check("clear_keeps_outs", outs_l, 8'h3C);

      // Consume on the same edge as the 8th accept
      send_bits(8'h4B, 7);
      check("pre8_outs", outs_l, 8'h3C);
      out_ready = 1'b1;
      in = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("swap_valid", {7'd0, out_valid_l}, 8'd1);
      check("swap_outs", outs_l, 8'h4B);
      check("swap_ready", {7'd0, in_ready_l}, 8'd1);
      check("swap_msb_outs", outs_m, 8'hD2);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("final_consumed", {7'd0, out_valid_l}, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
